// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, collector FSM states and the issue tag type.
// Shared by the operand demux and the result collector.
package alu_pkg;

   localparam int OP_ADD    = 0;
   localparam int OP_SUB    = 1;
   localparam int OP_MUL    = 2;
   localparam int OP_DIV    = 3;
   localparam int OP_AND    = 4;
   localparam int OP_OR     = 5;
   localparam int OP_XOR    = 6;
   localparam int OP_LI     = 7;
   localparam int NUM_UNITS = 8;
   localparam int UNIT_W    = $clog2(NUM_UNITS);

   localparam int TAG_SEL_W = 4;
   localparam int TAG_RD_W  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } coll_state_t;

   typedef struct packed {
      logic [TAG_SEL_W-1:0] opcode;
      logic [TAG_RD_W-1:0]  rd;
   } tag_t;

endpackage

// File: rtl/alu_result_collector_tag_fifo.sv
// tag_fifo: synchronous in-order FIFO with full/empty/count.
// DEPTH is a power of two so the pointers wrap on their own.
module tag_fifo #(
   parameter int  DEPTH = 4,
   parameter int  W     = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  count
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign full   = (r_count == FULL_CNT);
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign rdata  = r_mem[r_rptr];
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   // Entry storage, written at the write pointer; never cleared.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= wdata;
      end
   end

   // Pointers and occupancy; reset drops every queued entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: merges functional-unit results into one
// in-order writeback stream using a FIFO of issued {opcode, rd} tags.
// Optional: ALU_RESULT_COLLECTOR_STALL_CNT_EN adds a WAIT stall counter.
module alu_result_collector
   import alu_pkg::*;
#(
   parameter int N     = 16,
   parameter int SEL   = 4,
   parameter int RD_W  = 4,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [SEL-1:0]  issue_opcode,
   input  logic [RD_W-1:0] issue_rd,
   input  logic [7:0]      unit_valid,
   input  logic [8*N-1:0]  unit_result,
   output logic [7:0]      unit_ack,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [N-1:0]    wb_data,
   output logic            wb_err
`ifdef ALU_RESULT_COLLECTOR_STALL_CNT_EN
   ,
   output logic [15:0]     stall_cnt
`endif
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int          TW      = SEL + RD_W;
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   coll_state_t r_state;

   logic              r_wb_valid;
   logic [RD_W-1:0]   r_wb_rd;
   logic [N-1:0]      r_wb_data;
   logic              r_wb_err;

   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [AW:0]       w_count;
   logic [TW-1:0]     w_head;
   logic [SEL-1:0]    w_head_op;
   logic [RD_W-1:0]   w_head_rd;
   logic [UNIT_W-1:0] w_unit;
   logic              w_legal;
   logic              w_in_wait;
   logic              w_out_free;
   logic              w_capture;
   logic [N-1:0]      w_sel_result;

   tag_fifo #(
      .DEPTH (DEPTH),
      .W     (TW)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .wdata ({issue_opcode, issue_rd}),
      .pop   (w_pop),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Readiness is purely occupancy based: a full FIFO turns
   // issue away even in a cycle that retires the head.
   assign issue_ready = !w_full;
   assign w_push      = issue_valid && issue_ready && !rst;

   assign w_head_op  = w_head[TW-1:RD_W];
   assign w_head_rd  = w_head[RD_W-1:0];
   assign w_unit     = w_head_op[UNIT_W-1:0];
   assign w_legal    = (w_head_op[SEL-1:UNIT_W] == '0);
   assign w_in_wait  = (r_state == WAIT);
   assign w_out_free = !r_wb_valid || wb_ready;

   // Illegal opcodes retire without a unit; legal ones need the
   // head unit's result. Reset suppresses any capture or ack.
   assign w_capture = !rst && w_in_wait && !w_empty && w_out_free
                    && (w_legal ? unit_valid[w_unit] : 1'b1);
   assign w_pop     = w_capture;

   // Select the head unit's result lane.
   always_comb begin
      w_sel_result = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (w_unit == UNIT_W'(i)) begin
            w_sel_result = unit_result[i*N +: N];
         end
      end
   end

   // One-hot ack to the head unit in the cycle its result is taken.
   always_comb begin
      unit_ack = '0;
      if (w_capture && w_legal) begin
         unit_ack[w_unit] = 1'b1;
      end
   end

   // Collector FSM: WAIT while any tag is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_push) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (w_pop && !w_push && w_count == CNT_ONE) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Writeback register; holds stable while the register file stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_wb_err   <= 1'b0;
      end else if (w_capture) begin
         r_wb_valid <= 1'b1;
         r_wb_rd    <= w_head_rd;
         r_wb_data  <= w_legal ? w_sel_result : '0;
         r_wb_err   <= !w_legal;
      end else if (wb_ready) begin
         r_wb_valid <= 1'b0;
      end
   end

   assign wb_valid = r_wb_valid;
   assign wb_rd    = r_wb_rd;
   assign wb_data  = r_wb_data;
   assign wb_err   = r_wb_err;

`ifdef ALU_RESULT_COLLECTOR_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // Count WAIT cycles that retire nothing, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_in_wait && !w_pop && r_stall_cnt != 16'hFFFF) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed and random stimulus against a
// queue-based in-order model of the writeback stream.
module tb_alu_result_collector;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         issue_valid = 1'b0;
   logic         issue_ready;
   logic [3:0]   issue_opcode = '0;
   logic [3:0]   issue_rd = '0;
   logic [7:0]   unit_valid;
   logic [127:0] unit_result;
   logic [7:0]   unit_ack;
   logic         wb_valid;
   logic         wb_ready = 1'b1;
   logic [3:0]   wb_rd;
   logic [15:0]  wb_data;
   logic         wb_err;
`ifdef ALU_RESULT_COLLECTOR_STALL_CNT_EN
   logic [15:0]  stall_cnt;
`endif

   always #5 clk = ~clk;

   alu_result_collector dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_opcode (issue_opcode),
      .issue_rd     (issue_rd),
      .unit_valid   (unit_valid),
      .unit_result  (unit_result),
      .unit_ack     (unit_ack),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_err       (wb_err)
`ifdef ALU_RESULT_COLLECTOR_STALL_CNT_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   typedef struct {
      logic [3:0]  rd;
      logic [15:0] d;
      logic        e;
   } exp_t;

   exp_t        exp_q [$];
   logic [15:0] job_q [8][$];
   bit          go [8];
   bit          rnd = 1'b0;
   bit          done = 1'b0;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_go(input bit v);
      for (int i = 0; i < 8; i++) go[i] = v;
   endtask

   task automatic push_model(input logic [3:0] op, input logic [3:0] rd,
                             input logic [15:0] d);
      if (op < 8) job_q[op].push_back(d);
      exp_q.push_back('{rd, (op < 8) ? d : 16'h0, op >= 8});
   endtask

   // Issue one tag; returns at posedge+1 after acceptance.
   task automatic issue(input logic [3:0] op, input logic [3:0] rd,
                        input logic [15:0] d);
      bit acc;
      int t;
      t = 0;
      issue_valid  = 1'b1;
      issue_opcode = op;
      issue_rd     = rd;
      do begin
         @(negedge clk);
         acc = issue_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!acc && t < 300);
      issue_valid = 1'b0;
      if (!acc) chk("issue_timeout", 0, 1);
      else push_model(op, rd, d);
   endtask

   task automatic wait_wb(input string nm, input logic [3:0] rd,
                          input logic [15:0] d, input logic e,
                          output logic [7:0] seen);
      int t;
      t = 0;
      seen = '0;
      do begin
         @(negedge clk);
         t++;
         seen = seen | unit_ack;
      end while (!(wb_valid && wb_ready) && t < 300);
      if (!(wb_valid && wb_ready)) begin
         chk({nm, "_timeout"}, 0, 1);
      end else begin
         chk({nm, "_rd"}, wb_rd, rd);
         chk({nm, "_data"}, wb_data, d);
         chk({nm, "_err"}, wb_err, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      set_go(1'b1);
      wb_ready = 1'b1;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk({nm, "_drain"}, exp_q.size(), 0);
   endtask

   // Functional units: present queued results, hold until acked.
   initial begin : units
      logic [7:0] ack_s;
      logic       rst_s;
      unit_valid  = '0;
      unit_result = '0;
      forever begin
         @(negedge clk);
         ack_s = unit_ack;
         rst_s = rst;
         @(posedge clk);
         #1;
         for (int i = 0; i < 8; i++) begin
            if (rst_s) begin
               job_q[i].delete();
               unit_valid[i] = 1'b0;
            end else if (ack_s[i]) begin
               void'(job_q[i].pop_front());
               unit_valid[i] = 1'b0;
            end
            if (!unit_valid[i] && job_q[i].size() > 0
                && (rnd ? ($urandom_range(0, 2) == 0) : go[i])) begin
               unit_valid[i] = 1'b1;
               unit_result[i*16 +: 16] = job_q[i][0];
            end
         end
      end
   end

   // Compare process: every cycle against the in-order model.
   logic        p_hold = 1'b0;
   logic [3:0]  p_rd;
   logic [15:0] p_d;
   logic        p_e;
   exp_t        e_c;

   always @(negedge clk) begin
      if (rst) begin
         p_hold = 1'b0;
      end else begin
         chk("ack_onehot", $countones(unit_ack) <= 1, 1);
         chk("ack_needs_valid", unit_ack & ~unit_valid, 0);
         if (unit_ack != 0) chk("ack_out_free", !wb_valid || wb_ready, 1);
         chk("issue_ready", issue_ready, (exp_q.size() - wb_valid) < DEPTH);
         if (p_hold) begin
            chk("hold_valid", wb_valid, 1);
            chk("hold_rd", wb_rd, p_rd);
            chk("hold_data", wb_data, p_d);
            chk("hold_err", wb_err, p_e);
         end
         if (wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
               chk("wb_spurious", 1, 0);
            end else begin
               e_c = exp_q.pop_front();
               chk("wb_rd", wb_rd, e_c.rd);
               chk("wb_data", wb_data, e_c.d);
               chk("wb_err", wb_err, e_c.e);
            end
         end
         p_hold = wb_valid && !wb_ready;
         p_rd   = wb_rd;
         p_d    = wb_data;
         p_e    = wb_err;
      end
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      logic [7:0] seen;
      logic [3:0] op;
      int         t;

      set_go(1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_err", wb_err, 0);
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_unit_ack", unit_ack, 0);
      @(posedge clk);
      #1;

      // Single add.
      issue(4'd0, 4'd3, 16'h0012);
      @(posedge clk);
      #1;
      go[0] = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!unit_ack[0] && t < 20);
      chk("add_ack", unit_ack, 8'h01);
      @(negedge clk);
      chk("add_ack_once", unit_ack, 8'h00);
      chk("add_wb_valid", wb_valid, 1);
      chk("add_wb_rd", wb_rd, 3);
      chk("add_wb_data", wb_data, 16'h0012);
      chk("add_wb_err", wb_err, 0);
      @(posedge clk);
      #1;

      // Out-of-order unit completion.
      set_go(1'b0);
      issue(4'd2, 4'd1, 16'h0C00);
      issue(4'd4, 4'd2, 16'h00F0);
      go[4] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("ooo_no_ack", unit_ack, 0);
      end
      chk("ooo_u4_waiting", unit_valid[4], 1);
      @(posedge clk);
      #1;
      go[2] = 1'b1;
      wait_wb("ooo_first", 4'd1, 16'h0C00, 1'b0, seen);
      wait_wb("ooo_second", 4'd2, 16'h00F0, 1'b0, seen);

      // Backpressure with two pending results.
      set_go(1'b1);
      wb_ready = 1'b0;
      issue(4'd0, 4'd7, 16'h1111);
      issue(4'd1, 4'd8, 16'h2222);
      t = 0;
      while (!wb_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (3) begin
         chk("bp_rd", wb_rd, 7);
         chk("bp_data", wb_data, 16'h1111);
         chk("bp_no_ack", unit_ack, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      wb_ready = 1'b1;
      @(negedge clk);
      chk("bp_first_rd", wb_rd, 7);
      chk("bp_resume_ack", unit_ack, 8'h02);
      @(negedge clk);
      chk("bp_second_valid", wb_valid, 1);
      chk("bp_second_rd", wb_rd, 8);
      chk("bp_second_data", wb_data, 16'h2222);
      @(posedge clk);
      #1;
      drain("bp");

      // Full FIFO rejects issue even on a retire cycle.
      set_go(1'b0);
      for (int k = 0; k < 4; k++) issue(4'd3, 4'(10 + k), 16'(16'h3000 + k));
      @(negedge clk);
      chk("full_ready", issue_ready, 0);
`ifdef ALU_RESULT_COLLECTOR_STALL_CNT_EN
      chk("full_stall_grew", stall_cnt != 0, 1);
`endif
      @(posedge clk);
      #1;
      issue_valid  = 1'b1;
      issue_opcode = 4'd5;
      issue_rd     = 4'd14;
      go[3] = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!unit_ack[3] && t < 20);
      chk("full_retire_ack", unit_ack, 8'h08);
      chk("full_retire_ready", issue_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("full_next_ready", issue_ready, 1);
      @(posedge clk);
      #1;
      push_model(4'd5, 4'd14, 16'h5555);
      issue_valid = 1'b0;
      drain("full");

      // Illegal opcode.
      set_go(1'b1);
      issue(4'd9, 4'd5, 16'hBEEF);
      wait_wb("ill", 4'd5, 16'h0000, 1'b1, seen);
      chk("ill_no_ack", seen, 0);

      // Randomized traffic with random backpressure.
      rnd  = 1'b1;
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < 400; k++) begin
               if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(8, 15));
               else op = 4'($urandom_range(0, 7));
               issue(op, 4'($urandom), 16'($urandom));
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               wb_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            wb_ready = 1'b1;
         end
      join
      drain("rand");
      rnd = 1'b0;

      // Reset mid-operation.
      set_go(1'b0);
      go[0] = 1'b1;
      wb_ready = 1'b0;
      issue(4'd0, 4'd1, 16'hAAAA);
      issue(4'd1, 4'd2, 16'hB002);
      issue(4'd1, 4'd3, 16'hB003);
      issue(4'd1, 4'd4, 16'hB004);
      t = 0;
      while (!wb_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("rm_pre_valid", wb_valid, 1);
      chk("rm_pre_full", issue_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      set_go(1'b0);
      @(negedge clk);
      chk("rm_wb_valid", wb_valid, 0);
      chk("rm_issue_ready", issue_ready, 1);
      chk("rm_unit_ack", unit_ack, 0);
      chk("rm_wb_data", wb_data, 0);
`ifdef ALU_RESULT_COLLECTOR_STALL_CNT_EN
      chk("rm_stall_cnt", stall_cnt, 0);
`endif
      @(posedge clk);
      #1;
      wb_ready = 1'b1;
      go[0] = 1'b1;
      issue(4'd0, 4'd6, 16'h0042);
      wait_wb("rm_add", 4'd6, 16'h0042, 1'b0, seen);
      chk("rm_add_ack", seen, 8'h01);
      drain("end");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
